// File: rtl/triple_buffer_pkg.sv
// Shared constants for the three-frame capture buffer sequencer:
// one-hot buffer ids, reset role assignment and FSM state encodings.
package triple_buffer_pkg;

  localparam logic [2:0] BUF0 = 3'b001;
  localparam logic [2:0] BUF1 = 3'b010;
  localparam logic [2:0] BUF2 = 3'b100;

  // Roles after reset: writer, reader and spare each own one buffer.
  localparam logic [2:0] RST_W_BUF = BUF0;
  localparam logic [2:0] RST_R_BUF = BUF1;
  localparam logic [2:0] RST_S_BUF = BUF2;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_READ = 2'd2
  } r_state_t;

endpackage

// File: rtl/tb_addr_counter.sv
// Frame address counter: counts 0..MAX_TAP-1 on inc and wraps to 0 after the
// last tap. clear has priority over inc.
module tb_addr_counter #(
  parameter int MAX_TAP = 616,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [AW-1:0] count,
  output logic          at_last
);

  localparam logic [AW-1:0] LAST = AW'(MAX_TAP - 1);

  logic [AW-1:0] count_r;

  assign count   = count_r;
  assign at_last = (count_r == LAST);

  // Address register: clear, wrap on the last tap, or step by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (inc) begin
      if (at_last) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + AW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/triple_buffer_ctrl.sv
// Triple-buffer sequencer for the ETS capture buffer. Rotates write/read/spare
// roles so the writer never stalls and the reader only sees complete frames.
// Build option DROP_CNT_EN: when defined, drop_cnt counts frames overwritten
// before being read; otherwise drop_cnt is tied to zero.
module triple_buffer_ctrl
  import triple_buffer_pkg::*;
#(
  parameter int MAX_TAP = 616,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          w_sof,
  input  logic          w_valid,
  input  logic          r_req,
  input  logic          r_en,
  output logic [AW-1:0] waddr,
  output logic          w_occur,
  output logic [2:0]    w_buffer_id,
  output logic [AW-1:0] raddr,
  output logic          r_occur,
  output logic [2:0]    r_buffer_id,
  output logic          r_valid,
  output logic          r_last,
  output logic          fresh,
  output logic [15:0]   drop_cnt
);

  w_state_t   w_state_r;
  r_state_t   r_state_r;
  logic [2:0] w_buf_r;
  logic [2:0] r_buf_r;
  logic [2:0] spare_r;
  logic       fresh_r;
  logic       r_valid_r;

  logic w_occur_s;
  logic w_at_last_s;
  logic commit_s;
  logic r_occur_s;
  logic r_at_last_s;
  logic r_last_s;
  logic r_wants_s;
  logic take_s;

  // A w_sof on the final sample aborts the frame, so it never commits.
  assign w_occur_s = w_valid & (w_state_r == W_FILL);
  assign commit_s  = w_occur_s & w_at_last_s & ~w_sof;
  assign r_occur_s = r_en & (r_state_r == R_READ);
  assign r_last_s  = r_occur_s & r_at_last_s;
  // A waiting reader (or a fresh request) takes a frame that is already
  // committed or is committing this very cycle.
  assign r_wants_s = (r_state_r == R_WAIT) | ((r_state_r == R_IDLE) & r_req);
  assign take_s    = r_wants_s & (fresh_r | commit_s);

  tb_addr_counter #(.MAX_TAP(MAX_TAP), .AW(AW)) u_waddr (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_sof),
    .inc     (w_occur_s),
    .count   (waddr),
    .at_last (w_at_last_s)
  );

  tb_addr_counter #(.MAX_TAP(MAX_TAP), .AW(AW)) u_raddr (
    .clk     (clk),
    .rst     (rst),
    .clear   (take_s),
    .inc     (r_occur_s),
    .count   (raddr),
    .at_last (r_at_last_s)
  );

  // Write FSM: start on w_sof, return to idle once the last tap commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_r <= W_IDLE;
    end else begin
      case (w_state_r)
        W_IDLE:  w_state_r <= w_sof ? W_FILL : W_IDLE;
        W_FILL:  w_state_r <= commit_s ? W_IDLE : W_FILL;
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

  // Read FSM: request, wait for a committed frame, stream it out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_r <= R_IDLE;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (take_s) begin
            r_state_r <= R_READ;
          end else if (r_req) begin
            r_state_r <= R_WAIT;
          end else begin
            r_state_r <= R_IDLE;
          end
        end
        R_WAIT:  r_state_r <= take_s ? R_READ : R_WAIT;
        R_READ:  r_state_r <= r_last_s ? R_IDLE : R_READ;
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

  // Buffer role rotation and freshness flag; a simultaneous commit and take
  // hands the just-written buffer straight to the reader.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_buf_r <= RST_W_BUF;
      r_buf_r <= RST_R_BUF;
      spare_r <= RST_S_BUF;
      fresh_r <= 1'b0;
    end else if (commit_s && take_s) begin
      r_buf_r <= w_buf_r;
      w_buf_r <= spare_r;
      spare_r <= r_buf_r;
      fresh_r <= 1'b0;
    end else if (commit_s) begin
      w_buf_r <= spare_r;
      spare_r <= w_buf_r;
      fresh_r <= 1'b1;
    end else if (take_s) begin
      r_buf_r <= spare_r;
      spare_r <= r_buf_r;
      fresh_r <= 1'b0;
    end else begin
      w_buf_r <= w_buf_r;
      r_buf_r <= r_buf_r;
      spare_r <= spare_r;
      fresh_r <= fresh_r;
    end
  end

  // Read-data valid lines up with the one-cycle BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_r <= 1'b0;
    end else begin
      r_valid_r <= r_occur_s;
    end
  end

`ifdef DROP_CNT_EN
  logic [15:0] drop_r;

  // Count committed frames that replace an unread one; saturate at max.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 16'd0;
    end else if (commit_s && fresh_r && (drop_r != 16'hFFFF)) begin
      drop_r <= drop_r + 16'd1;
    end else begin
      drop_r <= drop_r;
    end
  end

  assign drop_cnt = drop_r;
`else
  assign drop_cnt = 16'd0;
`endif

  assign w_occur     = w_occur_s;
  assign w_buffer_id = w_buf_r;
  assign r_occur     = r_occur_s;
  assign r_buffer_id = r_buf_r;
  assign r_valid     = r_valid_r;
  assign r_last      = r_last_s;
  assign fresh       = fresh_r;

endmodule

// File: tb/tb_triple_buffer_ctrl.sv
// Self-checking bench for triple_buffer_ctrl. A BRAM model driven by the
// DUT strobes stores tagged samples; expected read data is queued as the
// reader is enabled and compared when r_valid appears.
module tb_triple_buffer_ctrl;

  localparam int MAX_TAP = 616;
  localparam int AW      = 10;
`ifdef DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, w_sof, w_valid, r_req, r_en;
  logic [AW-1:0] waddr, raddr;
  logic          w_occur, r_occur, r_valid, r_last, fresh;
  logic [2:0]    w_buffer_id, r_buffer_id;
  logic [15:0]   drop_cnt;

  logic [15:0]   wdata;
  logic [15:0]   rdata;
  logic [15:0]   mem [0:2][0:MAX_TAP-1];
  logic [15:0]   exp_q [$];

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  triple_buffer_ctrl #(.MAX_TAP(MAX_TAP), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .w_sof       (w_sof),
    .w_valid     (w_valid),
    .r_req       (r_req),
    .r_en        (r_en),
    .waddr       (waddr),
    .w_occur     (w_occur),
    .w_buffer_id (w_buffer_id),
    .raddr       (raddr),
    .r_occur     (r_occur),
    .r_buffer_id (r_buffer_id),
    .r_valid     (r_valid),
    .r_last      (r_last),
    .fresh       (fresh),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic int oh2i(input logic [2:0] oh);
    case (oh)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] mk(input int f, input int i);
    return {f[5:0], i[9:0]};
  endfunction

  // BRAM model: write on w_occur, registered read on r_occur.
  always @(posedge clk) begin
    if (w_occur) mem[oh2i(w_buffer_id)][waddr] <= wdata;
    if (r_occur) rdata <= mem[oh2i(r_buffer_id)][raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each r_valid pops one expected sample.
  always @(negedge clk) begin
    if (r_valid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rdata", {16'd0, rdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    w_sof = 1'b1; w_valid = 1'b0;
    step();
    w_sof = 1'b0;
  endtask

  task automatic samples(input int frame, input int n, input bit req_last);
    for (int i = 0; i < n; i++) begin
      w_valid = 1'b1;
      wdata   = mk(frame, i);
      r_req   = req_last && (i == n - 1);
      #1;
      chk("w_occur", {31'd0, w_occur}, 32'd1);
      chk("waddr", {22'd0, waddr}, i);
      step();
    end
    w_valid = 1'b0;
    r_req   = 1'b0;
  endtask

  task automatic read_frame(input int frame, input bit do_req, input logic [2:0] rid, input int n);
    int idx;
    int guard;
    if (do_req) begin
      r_req = 1'b1;
      step();
      r_req = 1'b0;
    end
    chk("r_buffer_id_take", {29'd0, r_buffer_id}, {29'd0, rid});
    chk("fresh_after_take", {31'd0, fresh}, 32'd0);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 4000) begin
      r_en = ($urandom_range(0, 3) != 0);
      #1;
      if (r_en) begin
        chk("r_occur", {31'd0, r_occur}, 32'd1);
        chk("raddr", {22'd0, raddr}, idx);
        chk("r_last", {31'd0, r_last}, {31'd0, (idx == MAX_TAP - 1)});
        exp_q.push_back(mk(frame, idx));
        idx++;
      end else begin
        chk("r_occur_idle_en", {31'd0, r_occur}, 32'd0);
      end
      step();
      guard++;
    end
    r_en = 1'b0;
    if (guard >= 4000) chk("read_timeout", 32'd1, 32'd0);
    if (n == MAX_TAP) begin
      step();
      step();
      chk("q_empty", exp_q.size(), 32'd0);
      chk("raddr_wrap", {22'd0, raddr}, 32'd0);
      r_en = 1'b1;
      #1;
      chk("r_occur_after_last", {31'd0, r_occur}, 32'd0);
      r_en = 1'b0;
    end
  endtask

  task automatic check_reset();
    chk("rst_w_id", {29'd0, w_buffer_id}, 32'd1);
    chk("rst_r_id", {29'd0, r_buffer_id}, 32'd2);
    chk("rst_fresh", {31'd0, fresh}, 32'd0);
    chk("rst_waddr", {22'd0, waddr}, 32'd0);
    chk("rst_raddr", {22'd0, raddr}, 32'd0);
    chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; w_sof = 1'b0; w_valid = 1'b0; r_req = 1'b0; r_en = 1'b0; wdata = 16'd0;
    step();
    step();
    rst = 1'b0;
    check_reset();

    // w_valid outside a frame is ignored.
    w_valid = 1'b1;
    #1;
    chk("w_occur_idle", {31'd0, w_occur}, 32'd0);
    step();
    w_valid = 1'b0;
    chk("waddr_idle", {22'd0, waddr}, 32'd0);

    // One frame then read it back.
    sof_pulse();
    samples(1, MAX_TAP, 1'b0);
    chk("commit1_w_id", {29'd0, w_buffer_id}, 32'd4);
    chk("commit1_fresh", {31'd0, fresh}, 32'd1);
    chk("waddr_wrap", {22'd0, waddr}, 32'd0);
    read_frame(1, 1'b1, 3'b001, MAX_TAP);

    // Two commits without a read: one dropped frame, newest is read.
    sof_pulse();
    samples(2, MAX_TAP, 1'b0);
    chk("commit2_w_id", {29'd0, w_buffer_id}, 32'd2);
    sof_pulse();
    samples(3, MAX_TAP, 1'b0);
    exp_drop++;
    chk("commit3_w_id", {29'd0, w_buffer_id}, 32'd4);
    chk("commit3_fresh", {31'd0, fresh}, 32'd1);
    chk("drop_1", {16'd0, drop_cnt}, DROP_EN ? exp_drop : 0);
    read_frame(3, 1'b1, 3'b010, MAX_TAP);

    // Request with nothing fresh waits, then takes on the next commit.
    r_req = 1'b1;
    step();
    r_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_en = 1'b1;
      #1;
      chk("wait_no_occur", {31'd0, r_occur}, 32'd0);
      step();
    end
    r_en = 1'b0;
    chk("wait_r_id", {29'd0, r_buffer_id}, 32'd2);
    sof_pulse();
    samples(4, MAX_TAP, 1'b0);
    chk("wait_take_w_id", {29'd0, w_buffer_id}, 32'd1);
    chk("drop_wait", {16'd0, drop_cnt}, DROP_EN ? exp_drop : 0);
    read_frame(4, 1'b0, 3'b100, MAX_TAP);

    // Commit and request in the same cycle while an older frame is fresh.
    sof_pulse();
    samples(5, MAX_TAP, 1'b0);
    chk("commit5_fresh", {31'd0, fresh}, 32'd1);
    sof_pulse();
    samples(6, MAX_TAP, 1'b1);
    exp_drop++;
    chk("same_w_id", {29'd0, w_buffer_id}, 32'd1);
    chk("same_disjoint", {29'd0, w_buffer_id & r_buffer_id}, 32'd0);
    chk("drop_same", {16'd0, drop_cnt}, DROP_EN ? exp_drop : 0);
    read_frame(6, 1'b0, 3'b010, MAX_TAP);

    // Abort at waddr 300, then a full frame without a new w_sof.
    sof_pulse();
    samples(99, 300, 1'b0);
    w_sof = 1'b1;
    #1;
    chk("abort_waddr_pre", {22'd0, waddr}, 32'd300);
    step();
    w_sof = 1'b0;
    chk("abort_waddr", {22'd0, waddr}, 32'd0);
    chk("abort_fresh", {31'd0, fresh}, 32'd0);
    chk("abort_w_id", {29'd0, w_buffer_id}, 32'd1);
    samples(7, MAX_TAP, 1'b0);
    chk("commit7_fresh", {31'd0, fresh}, 32'd1);
    chk("commit7_w_id", {29'd0, w_buffer_id}, 32'd4);
    read_frame(7, 1'b1, 3'b001, MAX_TAP);

    // Reset in the middle of a read.
    sof_pulse();
    samples(8, MAX_TAP, 1'b0);
    read_frame(8, 1'b1, 3'b100, 100);
    rst = 1'b1;
    step();
    check_reset();
    chk("rst_q_empty", exp_q.size(), 32'd0);
    rst = 1'b0;
    r_en = 1'b1;
    #1;
    chk("rst_r_occur", {31'd0, r_occur}, 32'd0);
    r_en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
